rtype_pipe_cpu: RTL
===================

# rtype_pipe_cpu

Parametrised five-stage (IF/ID/EX/MEM/WB) integer pipeline executing MIPS-format R-type instructions plus `addi`, `multu` and a halt. It is the next generation of the course CPU:
- dedicated PC instead of register 31;
- load port for instruction memory;
- full EX-stage operand forwarding;
- HI/LO state;
- halt and illegal-instruction reporting;
- a debug read port, so benches check results without hierarchical peeks.

## Interface
- DATA_W, 32, datapath and register width (≥ 8)
- IMEM_DEPTH, 128, instruction words; power of two; AW = log2(IMEM_DEPTH)
- NUM_REGS, 32, architectural registers (≤ 32); register 0 reads 0
- clka  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = fetch/advance; 0 = pipeline frozen and imem loadable
- imem_we  in  1  instruction write strobe, honoured only while run=0
- imem_addr  in  AW  instruction write address
- imem_wdata  in  32  instruction word
- dbg_addr  in  5  register to observe
- dbg_data  out  DATA_W  combinational register-file read of dbg_addr (0 if ≥ NUM_REGS)
- pc  out  AW  word address of next fetch
- retire  out  1  one-cycle pulse per non-bubble instruction leaving WB
- halted  out  1  sticky; halt instruction reached WB
- illegal  out  1  sticky; unsupported encoding reached WB

## Operation
- Encoding fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
- Register indices ≥ NUM_REGS read 0; writes to them are dropped.
- op=0 functs:
  - add 100000, sub 100010, and 100100, or 100101: rd = rs op rt
  - slt 101010: signed compare
  - sll 000000, srl 000010: rd = rt shifted by shamt
  - mfhi 010000 / mflo 010010: rd = HI / LO
  - multu 011001: {HI,LO} = rs*rt unsigned, 2·DATA_W product, no rd write
- op=001000 addi: rt = rs + sign-extended imm[15:0].
- op=111111 halt.
- Word 0 is `sll $0,$0,0` and acts as a nop.
- Arithmetic wraps modulo 2^DATA_W; no overflow traps.
- Any other op/funct is a nop; it sets illegal when it reaches WB.
- Writes to register 0 are discarded.
- Register file is written in WB. ID read is write-through: WB write data is visible to the same-cycle ID read.
- EX operand forwarding:
  - Sources are the EX/MEM result (priority) and the MEM/WB result.
  - Match on destination register ≠ 0 and writing instruction.
  - No stalls ever required.
- HI/LO are updated on the edge leaving EX; an mfhi/mflo immediately following multu sees the new value.
- MEM stage is a pass-through register; there are no loads or stores.
- PC increments by 1 word per advancing cycle and wraps IMEM_DEPTH-1 → 0.
- Halt behaviour:
  - When halt is captured into IF/ID, PC freezes and IF injects nops.
  - Older instructions drain normally.
  - halted sets when the halt reaches WB; retire does not pulse for halt.
- run=0 freezes every pipeline register, PC, HI/LO and the register file. Imem writes occur on that edge.
- Loading imem while run=1 is ignored.

## Timing
- Reset (asynchronous, takes effect immediately):
  - pc=0, all pipeline latches = nop, registers=0, HI=LO=0.
  - retire=0, halted=0, illegal=0.
  - imem contents are retained.
- An instruction fetched from pc on edge k (first edge with run=1) is in ID after k, EX after k+1, MEM after k+2, WB after k+3.
- Its register write and retire pulse occur on edge k+4.
- A new result is visible on dbg_data after edge k+4.
- Back-to-back dependency distance 1 and 2 are resolved by forwarding; distance 3 is resolved by write-through.
- halted rises on the edge that would retire the halt: 4 edges after it entered IF/ID. It remains set until rst_n is asserted.
- run deasserted mid-program, then reasserted: execution resumes identically with no lost or duplicated instruction.
- rst_n asserted mid-pipeline discards all in-flight instructions; no partial writes.

## Test plan
- Load addi $1,$0,5; addi $2,$0,7; add $3,$1,$2; sub $4,$3,$1, then run → $3=12 and $4=7. Both forwarding paths are used; each retire is 1 cycle apart, first at edge 5.
- $1=0xFFFFFFFF (addi $1,$0,-1), $2=2; multu $1,$2; mfhi $5; mflo $6 → $5=1, $6=0xFFFFFFFE.
- addi $0,$0,9; add $7,$0,$0 → $0 reads 0 and $7=0. srl $8,$1,4 with $1=0xFFFFFFFF → $8=0x0FFFFFFF.
- Program of three addis, then halt at address 3 → halted rises exactly at edge 8 after run; pc holds 4; words after the halt never execute.
- Word 0xFC00_0000 is halt; word 0x0000_003F is an illegal funct. Executing the illegal funct sets illegal with no register change; slt with -1 vs 1 gives 1.
- Pulse rst_n low during the 3rd cycle of a running program → all outputs return to reset values immediately. Rerunning gives the same final registers as an uninterrupted run. A run=0 gap inserted mid-program produces identical results.

Source files
------------

// File: rtl/rtype_pipe_cpu_if.sv
// rtype_pipe_cpu_if: run control, imem load port, debug read port and status of rtype_pipe_cpu
interface rtype_pipe_cpu_if #(
  parameter int DATA_W = 32,
  parameter int AW = 7
);
  logic run;
  logic imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [4:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic [AW-1:0] pc;
  logic retire;
  logic halted;
  logic illegal;
  modport master (
    output run, imem_we, imem_addr, imem_wdata, dbg_addr,
    input dbg_data, pc, retire, halted, illegal
  );
  modport slave (
    input run, imem_we, imem_addr, imem_wdata, dbg_addr,
    output dbg_data, pc, retire, halted, illegal
  );
endinterface

// File: rtl/rtype_pipe_cpu.sv
// rtype_pipe_cpu: five-stage MIPS R-type/addi/multu/halt pipeline with EX forwarding and HI/LO
module rtype_pipe_cpu #(
  parameter int DATA_W = 32,
  parameter int IMEM_DEPTH = 128,
  parameter int NUM_REGS = 32
) (
  input logic clka,
  input logic rst_n,
  rtype_pipe_cpu_if.slave bus
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam logic [31:0] REG_OK = (NUM_REGS >= 32) ? '1 : (32'd1 << NUM_REGS) - 32'd1;
  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_SLL, OP_SRL,
    OP_MFHI, OP_MFLO, OP_MULTU, OP_ADDI
  } alu_op_e;
  logic [31:0] r_imem [IMEM_DEPTH];
  logic [DATA_W-1:0] r_regs [32];
  logic [AW-1:0] r_pc;
  logic r_stop;
  logic [31:0] r_id_ir;
  logic r_id_v;
  alu_op_e r_ex_op;
  logic [DATA_W-1:0] r_ex_a, r_ex_b, r_ex_imm;
  logic [4:0] r_ex_rs, r_ex_rt, r_ex_wd, r_ex_sh;
  logic r_ex_we, r_ex_v, r_ex_halt, r_ex_ill;
  logic [DATA_W-1:0] r_mem_res, r_wb_res;
  logic [4:0] r_mem_wd, r_wb_wd;
  logic r_mem_we, r_mem_v, r_mem_halt, r_mem_ill;
  logic r_wb_we, r_wb_v, r_wb_halt, r_wb_ill;
  logic [DATA_W-1:0] r_hi, r_lo;
  logic r_retire, r_halted, r_illegal;
  logic [31:0] w_if_ir;
  logic w_if_halt;
  logic [5:0] w_op, w_fn;
  logic [4:0] w_rs, w_rt, w_rd, w_sh, w_dest;
  alu_op_e w_dop;
  logic w_dhalt, w_dill, w_dwe;
  logic [DATA_W-1:0] w_ra, w_rb, w_imm, w_fa, w_fb, w_res;
  logic [2*DATA_W-1:0] w_prod;
  assign w_if_ir = r_stop ? 32'h0 : r_imem[r_pc];
  assign w_if_halt = w_if_ir[31:26] == 6'h3F;
  assign w_op = r_id_ir[31:26];
  assign w_rs = r_id_ir[25:21];
  assign w_rt = r_id_ir[20:16];
  assign w_rd = r_id_ir[15:11];
  assign w_sh = r_id_ir[10:6];
  assign w_fn = r_id_ir[5:0];
  always_comb begin
    w_dop = OP_NOP;
    if (w_op == 6'h00)
      case (w_fn)
        6'h20: w_dop = OP_ADD;
        6'h22: w_dop = OP_SUB;
        6'h24: w_dop = OP_AND;
        6'h25: w_dop = OP_OR;
        6'h2A: w_dop = OP_SLT;
        6'h00: w_dop = OP_SLL;
        6'h02: w_dop = OP_SRL;
        6'h10: w_dop = OP_MFHI;
        6'h12: w_dop = OP_MFLO;
        6'h19: w_dop = OP_MULTU;
        default: w_dop = OP_NOP;
      endcase
    else if (w_op == 6'h08)
      w_dop = OP_ADDI;
  end
  assign w_dhalt = r_id_v && w_op == 6'h3F;
  assign w_dill = r_id_v && w_dop == OP_NOP && w_op != 6'h3F;
  assign w_dest = (w_dop == OP_ADDI) ? w_rt : w_rd;
  assign w_dwe = r_id_v && w_dop != OP_NOP && w_dop != OP_MULTU && w_dest != 5'd0 && REG_OK[w_dest];
  // Write-through read: a WB write to the same register wins over the array.
  assign w_ra = !REG_OK[w_rs] ? '0 : (r_wb_we && r_wb_wd == w_rs) ? r_wb_res : r_regs[w_rs];
  assign w_rb = !REG_OK[w_rt] ? '0 : (r_wb_we && r_wb_wd == w_rt) ? r_wb_res : r_regs[w_rt];
  assign w_imm = DATA_W'($signed(r_id_ir[15:0]));
  // we flags already exclude $0 and out-of-range registers, so no extra index checks.
  assign w_fa = (r_mem_we && r_mem_wd == r_ex_rs) ? r_mem_res :
                (r_wb_we && r_wb_wd == r_ex_rs) ? r_wb_res : r_ex_a;
  assign w_fb = (r_mem_we && r_mem_wd == r_ex_rt) ? r_mem_res :
                (r_wb_we && r_wb_wd == r_ex_rt) ? r_wb_res : r_ex_b;
  assign w_prod = {{DATA_W{1'b0}}, w_fa} * {{DATA_W{1'b0}}, w_fb};
  always_comb begin
    w_res = '0;
    case (r_ex_op)
      OP_ADD: w_res = w_fa + w_fb;
      OP_SUB: w_res = w_fa - w_fb;
      OP_AND: w_res = w_fa & w_fb;
      OP_OR: w_res = w_fa | w_fb;
      OP_SLT: w_res = {{(DATA_W-1){1'b0}}, $signed(w_fa) < $signed(w_fb)};
      OP_SLL: w_res = w_fb << r_ex_sh;
      OP_SRL: w_res = w_fb >> r_ex_sh;
      OP_MFHI: w_res = r_hi;
      OP_MFLO: w_res = r_lo;
      OP_ADDI: w_res = w_fa + r_ex_imm;
      default: w_res = '0;
    endcase
  end
  always_ff @(posedge clka)
    if (!bus.run && bus.imem_we) r_imem[bus.imem_addr] <= bus.imem_wdata;
  always_ff @(posedge clka or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
      r_pc <= '0;
      r_stop <= 1'b0;
      r_id_ir <= '0;
      r_id_v <= 1'b0;
      r_ex_op <= OP_NOP;
      r_ex_a <= '0;
      r_ex_b <= '0;
      r_ex_imm <= '0;
      r_ex_rs <= '0;
      r_ex_rt <= '0;
      r_ex_wd <= '0;
      r_ex_sh <= '0;
      r_ex_we <= 1'b0;
      r_ex_v <= 1'b0;
      r_ex_halt <= 1'b0;
      r_ex_ill <= 1'b0;
      r_mem_res <= '0;
      r_mem_wd <= '0;
      r_mem_we <= 1'b0;
      r_mem_v <= 1'b0;
      r_mem_halt <= 1'b0;
      r_mem_ill <= 1'b0;
      r_wb_res <= '0;
      r_wb_wd <= '0;
      r_wb_we <= 1'b0;
      r_wb_v <= 1'b0;
      r_wb_halt <= 1'b0;
      r_wb_ill <= 1'b0;
      r_hi <= '0;
      r_lo <= '0;
      r_retire <= 1'b0;
      r_halted <= 1'b0;
      r_illegal <= 1'b0;
    end else if (bus.run) begin
      r_pc <= r_stop ? r_pc : r_pc + 1'b1;
      r_stop <= r_stop | w_if_halt;
      r_id_ir <= w_if_ir;
      r_id_v <= !r_stop;
      r_ex_op <= w_dop;
      r_ex_a <= w_ra;
      r_ex_b <= w_rb;
      r_ex_imm <= w_imm;
      r_ex_rs <= w_rs;
      r_ex_rt <= w_rt;
      r_ex_wd <= w_dest;
      r_ex_sh <= w_sh;
      r_ex_we <= w_dwe;
      r_ex_v <= r_id_v;
      r_ex_halt <= w_dhalt;
      r_ex_ill <= w_dill;
      if (r_ex_op == OP_MULTU) {r_hi, r_lo} <= w_prod;
      r_mem_res <= w_res;
      r_mem_wd <= r_ex_wd;
      r_mem_we <= r_ex_we;
      r_mem_v <= r_ex_v;
      r_mem_halt <= r_ex_halt;
      r_mem_ill <= r_ex_ill;
      r_wb_res <= r_mem_res;
      r_wb_wd <= r_mem_wd;
      r_wb_we <= r_mem_we;
      r_wb_v <= r_mem_v;
      r_wb_halt <= r_mem_halt;
      r_wb_ill <= r_mem_ill;
      if (r_wb_we) r_regs[r_wb_wd] <= r_wb_res;
      r_retire <= r_wb_v && !r_wb_halt;
      r_halted <= r_halted | r_wb_halt;
      r_illegal <= r_illegal | r_wb_ill;
    end else
      r_retire <= 1'b0;
  assign bus.dbg_data = REG_OK[bus.dbg_addr] ? r_regs[bus.dbg_addr] : '0;
  assign bus.pc = r_pc;
  assign bus.retire = r_retire;
  assign bus.halted = r_halted;
  assign bus.illegal = r_illegal;
endmodule
